// File: rtl/exmu_line_server_pkg.sv
// Shared constants and FSM encoding for the ExMU line server.
// A line is 32 points of 64 bits each, placed at 256-byte strides in point memory.
package exmu_line_server_pkg;
   localparam int EXMU_POINTS_PER_LINE = 32;
   localparam int EXMU_POINT_BITS      = 64;
   localparam int EXMU_LINE_BITS       = 2048;
   localparam int EXMU_LINE_BYTES_LOG2 = 8;
   localparam int EXMU_ID_LINE_MSB     = 18;
   localparam int EXMU_ID_LINE_LSB     = 5;
   localparam int EXMU_LINE_IDX_W      = EXMU_ID_LINE_MSB - EXMU_ID_LINE_LSB + 1;
   localparam int EXMU_BEAT_W          = 5;
   localparam int EXMU_CNT_W           = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_XFER = 3'd1,
      ST_RD_DONE = 3'd2,
      ST_WR_XFER = 3'd3,
      ST_WR_DONE = 3'd4
   } exmu_state_e;
endpackage

// File: rtl/exmu_beat_addr_gen.sv
// Byte address of one 64-bit beat: base + line*256 + beat*8, truncated to the bus width.
module exmu_beat_addr_gen
   import exmu_line_server_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          ADDR_WIDTH = 32
) (
   input  logic [EXMU_LINE_IDX_W-1:0] i_line,
   input  logic [EXMU_BEAT_W-1:0]     i_beat,
   output logic [ADDR_WIDTH-1:0]      o_addr
);
   localparam int OFS_W = EXMU_LINE_IDX_W + EXMU_LINE_BYTES_LOG2;

   logic [OFS_W-1:0] ofs;

   always_comb begin
      ofs    = {i_line, i_beat, 3'b000};
      o_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(ofs);
   end
endmodule

// File: rtl/exmu_line_server.sv
// Memory-side responder for the ExMU line cache: gathers 32 read beats into a line,
// or scatters a captured line into 32 write beats. One operation in flight at a time.
module exmu_line_server
   import exmu_line_server_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          ADDR_WIDTH = 32
) (
   input  logic                      i_SYSTEM_clk,
   input  logic                      i_SYSTEM_rst,
   input  logic                      i_ExMU_readReq,
   input  logic [18:0]               i_ExMU_readID,
   output logic [EXMU_LINE_BITS-1:0] o_INT_readPayload,
   output logic                      o_INT_readDone,
   input  logic                      i_ExMU_writeReq,
   input  logic [18:0]               i_ExMU_writeID,
   input  logic [EXMU_LINE_BITS-1:0] i_ExMU_writePayload,
   output logic                      o_INT_writeDone,
   output logic                      o_INT_busy,
   output logic [ADDR_WIDTH-1:0]     o_MEM_addr,
   output logic                      o_MEM_rdReq,
   input  logic                      i_MEM_rdReady,
   input  logic                      i_MEM_rdValid,
   input  logic [63:0]               i_MEM_rdData,
   output logic                      o_MEM_wrValid,
   output logic [63:0]               o_MEM_wrData,
   input  logic                      i_MEM_wrReady
);
   localparam logic [EXMU_CNT_W-1:0] CNT_FULL = EXMU_CNT_W'(EXMU_POINTS_PER_LINE);
   localparam logic [EXMU_CNT_W-1:0] CNT_LAST = EXMU_CNT_W'(EXMU_POINTS_PER_LINE - 1);

   exmu_state_e                 state_q, state_d;
   logic [EXMU_LINE_IDX_W-1:0]  line_q, line_d;
   logic [EXMU_CNT_W-1:0]       req_cnt_q, req_cnt_d;
   logic [EXMU_CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
   logic [EXMU_LINE_BITS-1:0]   payload_q, payload_d;
   logic [EXMU_LINE_BITS-1:0]   wbuf_q, wbuf_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic                        rd_done_q, rd_done_d;
   logic                        wr_done_q, wr_done_d;

   logic [EXMU_LINE_IDX_W-1:0]  gen_line;
   logic [EXMU_BEAT_W-1:0]      gen_beat;
   logic [ADDR_WIDTH-1:0]       gen_addr;
   logic                        req_open, rd_hs, rd_cap, wr_hs;
   logic                        unused_id_bits;

   assign unused_id_bits = ^{i_ExMU_readID[EXMU_ID_LINE_LSB-1:0], i_ExMU_writeID[EXMU_ID_LINE_LSB-1:0]};

   // Single generator: during a transfer it always looks one beat ahead so the
   // registered address is ready in the cycle after each handshake.
   exmu_beat_addr_gen #(
      .BASE_ADDR  (BASE_ADDR),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .i_line (gen_line),
      .i_beat (gen_beat),
      .o_addr (gen_addr)
   );

   always_comb begin
      req_open  = (req_cnt_q < CNT_FULL);
      rd_hs     = (state_q == ST_RD_XFER) && req_open && i_MEM_rdReady;
      rd_cap    = (state_q == ST_RD_XFER) && (rsp_cnt_q < CNT_FULL) && i_MEM_rdValid;
      wr_hs     = (state_q == ST_WR_XFER) && req_open && i_MEM_wrReady;

      state_d   = state_q;
      line_d    = line_q;
      req_cnt_d = req_cnt_q;
      rsp_cnt_d = rsp_cnt_q;
      payload_d = payload_q;
      wbuf_d    = wbuf_q;
      addr_d    = addr_q;
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
      gen_line  = line_q;
      gen_beat  = req_cnt_q[EXMU_BEAT_W-1:0] + 5'd1;

      case (state_q)
         ST_IDLE: begin
            if (i_ExMU_writeReq) begin
               state_d   = ST_WR_XFER;
               line_d    = i_ExMU_writeID[EXMU_ID_LINE_MSB:EXMU_ID_LINE_LSB];
               wbuf_d    = i_ExMU_writePayload;
               req_cnt_d = '0;
               rsp_cnt_d = '0;
               gen_line  = line_d;
               gen_beat  = '0;
               addr_d    = gen_addr;
            end else if (i_ExMU_readReq) begin
               state_d   = ST_RD_XFER;
               line_d    = i_ExMU_readID[EXMU_ID_LINE_MSB:EXMU_ID_LINE_LSB];
               req_cnt_d = '0;
               rsp_cnt_d = '0;
               gen_line  = line_d;
               gen_beat  = '0;
               addr_d    = gen_addr;
            end
         end
         ST_RD_XFER: begin
            if (rd_hs) begin
               req_cnt_d = req_cnt_q + 6'd1;
               if (req_cnt_q != CNT_LAST) addr_d = gen_addr;
            end
            if (rd_cap) begin
               payload_d[rsp_cnt_q[EXMU_BEAT_W-1:0]*EXMU_POINT_BITS +: EXMU_POINT_BITS] = i_MEM_rdData;
               rsp_cnt_d = rsp_cnt_q + 6'd1;
            end
            if (rsp_cnt_d == CNT_FULL) begin
               state_d   = ST_RD_DONE;
               rd_done_d = 1'b1;
            end
         end
         ST_WR_XFER: begin
            if (wr_hs) begin
               req_cnt_d = req_cnt_q + 6'd1;
               if (req_cnt_q == CNT_LAST) begin
                  state_d   = ST_WR_DONE;
                  wr_done_d = 1'b1;
               end else begin
                  addr_d = gen_addr;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_SYSTEM_clk) begin
      if (!i_SYSTEM_rst) begin
         state_q   <= ST_IDLE;
         line_q    <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
         payload_q <= '0;
         wbuf_q    <= '0;
         addr_q    <= '0;
         rd_done_q <= 1'b0;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         payload_q <= payload_d;
         wbuf_q    <= wbuf_d;
         addr_q    <= addr_d;
         rd_done_q <= rd_done_d;
         wr_done_q <= wr_done_d;
      end
   end

   assign o_INT_busy        = (state_q != ST_IDLE);
   assign o_INT_readPayload = payload_q;
   assign o_INT_readDone    = rd_done_q;
   assign o_INT_writeDone   = wr_done_q;
   assign o_MEM_addr        = addr_q;
   assign o_MEM_rdReq       = (state_q == ST_RD_XFER) && req_open;
   assign o_MEM_wrValid     = (state_q == ST_WR_XFER) && req_open;
   assign o_MEM_wrData      = o_MEM_wrValid ?
                              wbuf_q[req_cnt_q[EXMU_BEAT_W-1:0]*EXMU_POINT_BITS +: EXMU_POINT_BITS] : 64'd0;
endmodule

// File: tb/tb_exmu_line_server.sv
// Directed bench for exmu_line_server: a behavioural point memory answers beat requests
// at each falling edge, and the main sequence checks results with immediate assertions.
module tb_exmu_line_server;
   logic          clk;
   logic          rst;
   logic          read_req;
   logic [18:0]   read_id;
   logic [2047:0] read_payload;
   logic          read_done;
   logic          write_req;
   logic [18:0]   write_id;
   logic [2047:0] write_payload;
   logic          write_done;
   logic          busy;
   logic [31:0]   mem_addr;
   logic          mem_rd_req;
   logic          mem_rd_ready;
   logic          mem_rd_valid;
   logic [63:0]   mem_rd_data;
   logic          mem_wr_valid;
   logic [63:0]   mem_wr_data;
   logic          mem_wr_ready;

   exmu_line_server dut (
      .i_SYSTEM_clk        (clk),
      .i_SYSTEM_rst        (rst),
      .i_ExMU_readReq      (read_req),
      .i_ExMU_readID       (read_id),
      .o_INT_readPayload   (read_payload),
      .o_INT_readDone      (read_done),
      .i_ExMU_writeReq     (write_req),
      .i_ExMU_writeID      (write_id),
      .i_ExMU_writePayload (write_payload),
      .o_INT_writeDone     (write_done),
      .o_INT_busy          (busy),
      .o_MEM_addr          (mem_addr),
      .o_MEM_rdReq         (mem_rd_req),
      .i_MEM_rdReady       (mem_rd_ready),
      .i_MEM_rdValid       (mem_rd_valid),
      .i_MEM_rdData        (mem_rd_data),
      .o_MEM_wrValid       (mem_wr_valid),
      .o_MEM_wrData        (mem_wr_data),
      .i_MEM_wrReady       (mem_wr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory model state
   int          rsp_q[$];
   logic        rd_toggle = 1'b0;
   logic        rd_rand   = 1'b0;
   logic [31:0] rd_base   = 32'h0;
   int          rd_reqs   = 0;
   int          rd_bad    = 0;
   int          rd_done_cnt = 0;
   logic        stall_en  = 1'b0;
   int          stall_cnt = 0;
   logic [31:0] wr_base   = 32'h0;
   logic [63:0] wr_pat    = 64'h0;
   int          wr_beats  = 0;
   int          wr_bad    = 0;
   int          wr_done_cnt = 0;

   logic [2047:0] exp_rd;
   logic [2047:0] wpay;
   int            lat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
      int fk;
      fk = 0;
      for (int k = 31; k >= 0; k--) if (obs[k*64 +: 64] !== exp[k*64 +: 64]) fk = k;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s beat %0d observed=%0h expected=%0h", tag, fk, obs[fk*64 +: 64], exp[fk*64 +: 64]);
      end
   endtask

   // Runs at the falling edge: observes outputs settled after the rising edge and
   // sets memory-side inputs for the next rising edge.
   task automatic mem_model();
      int idx;
      if (rsp_q.size() > 0 && (!rd_rand || $urandom_range(0, 2) == 0)) begin
         idx          = rsp_q.pop_front();
         mem_rd_valid = 1'b1;
         mem_rd_data  = 64'hA000 + 64'(idx);
      end else begin
         mem_rd_valid = 1'b0;
         mem_rd_data  = 64'h0;
      end
      mem_rd_ready = rd_toggle ? ~mem_rd_ready : 1'b1;
      if (mem_rd_req && mem_rd_ready) begin
         if (mem_addr !== rd_base + 32'(rd_reqs * 8)) rd_bad++;
         rsp_q.push_back(rd_reqs);
         rd_reqs++;
      end
      if (mem_wr_valid) begin
         if (stall_en && wr_beats == 7 && stall_cnt < 5) begin
            mem_wr_ready = 1'b0;
            stall_cnt++;
            if (mem_wr_data !== wr_pat + 64'd7 || mem_addr !== wr_base + 32'd56) wr_bad++;
         end else begin
            mem_wr_ready = 1'b1;
            if (mem_wr_data !== wr_pat + 64'(wr_beats) || mem_addr !== wr_base + 32'(wr_beats * 8)) wr_bad++;
            wr_beats++;
         end
      end else begin
         mem_wr_ready = 1'b1;
      end
      if (read_done) rd_done_cnt++;
      if (write_done) wr_done_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      mem_model();
   endtask

   task automatic clear_counts();
      rsp_q.delete();
      rd_reqs = 0; rd_bad = 0; rd_done_cnt = 0;
      wr_beats = 0; wr_bad = 0; wr_done_cnt = 0; stall_cnt = 0;
   endtask

   initial begin
      rst = 1'b0; read_req = 1'b1; read_id = 19'h0; write_req = 1'b0; write_id = 19'h0;
      write_payload = '0; mem_rd_ready = 1'b1; mem_rd_valid = 1'b0; mem_rd_data = 64'h0;
      mem_wr_ready = 1'b1;
      for (int k = 0; k < 32; k++) exp_rd[k*64 +: 64] = 64'hA000 + 64'(k);

      // 1: reset held with a pending read request
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rdreq", 64'(mem_rd_req), 64'd0);
      chk("rst_wrvalid", 64'(mem_wr_valid), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wrdata", mem_wr_data, 64'd0);
      chk("rst_dones", {62'd0, read_done, write_done}, 64'd0);
      chk_line("rst_payload", read_payload, '0);
      rst = 1'b1; read_req = 1'b0;
      tick();
      chk("post_rst_busy", 64'(busy), 64'd0);
      clear_counts();

      // 2: zero-wait read of line 2
      rd_base = 32'h200; read_id = 19'h00045; read_req = 1'b1;
      tick(); read_req = 1'b0; lat = 1;
      chk("rd_busy", 64'(busy), 64'd1);
      while (rd_done_cnt == 0 && lat < 200) begin tick(); lat++; end
      chk("rd_latency", 64'(lat), 64'd34);
      chk_line("rd_payload", read_payload, exp_rd);
      repeat (3) tick();
      chk("rd_done_once", 64'(rd_done_cnt), 64'd1);
      chk("rd_req_count", 64'(rd_reqs), 64'd32);
      chk("rd_addr_seq", 64'(rd_bad), 64'd0);
      chk("rd_addr_hold", 64'(mem_addr), 64'h2F8);
      chk("rd_idle_busy", 64'(busy), 64'd0);

      // 3: read with toggling ready and random response delay
      clear_counts(); rd_toggle = 1'b1; rd_rand = 1'b1;
      read_req = 1'b1;
      tick(); read_req = 1'b0; lat = 1;
      while (rd_done_cnt == 0 && lat < 1000) begin tick(); lat++; end
      chk("bp_done_seen", 64'(rd_done_cnt), 64'd1);
      repeat (10) tick();
      chk("bp_req_count", 64'(rd_reqs), 64'd32);
      chk("bp_addr_seq", 64'(rd_bad), 64'd0);
      chk("bp_done_once", 64'(rd_done_cnt), 64'd1);
      chk_line("bp_payload", read_payload, exp_rd);
      rd_toggle = 1'b0; rd_rand = 1'b0; mem_rd_ready = 1'b1;

      // 4: write of line 1 with a 5-cycle stall at beat 7
      clear_counts(); stall_en = 1'b1; wr_base = 32'h100; wr_pat = 64'h0;
      for (int k = 0; k < 32; k++) wpay[k*64 +: 64] = 64'(k);
      write_id = 19'h00020; write_payload = wpay; write_req = 1'b1;
      tick(); write_req = 1'b0; write_payload = '1; lat = 1;
      chk("wr_busy", 64'(busy), 64'd1);
      while (wr_done_cnt == 0 && lat < 200) begin tick(); lat++; end
      chk("wr_latency", 64'(lat), 64'd38);
      repeat (3) tick();
      chk("wr_beats", 64'(wr_beats), 64'd32);
      chk("wr_data_addr", 64'(wr_bad), 64'd0);
      chk("wr_stall_cycles", 64'(stall_cnt), 64'd5);
      chk("wr_done_once", 64'(wr_done_cnt), 64'd1);
      chk("wr_addr_hold", 64'(mem_addr), 64'h1F8);
      chk("wr_idle_valid", 64'(mem_wr_valid), 64'd0);
      stall_en = 1'b0;

      // 5: simultaneous read+write; write wins, later read ignored while busy
      clear_counts(); wr_base = 32'h300; wr_pat = 64'hB0000; rd_base = 32'h500;
      for (int k = 0; k < 32; k++) wpay[k*64 +: 64] = 64'hB0000 + 64'(k);
      write_id = 19'h00060; write_payload = wpay; write_req = 1'b1;
      read_id = 19'h000A0; read_req = 1'b1;
      tick(); write_req = 1'b0; read_req = 1'b0; lat = 1;
      repeat (9) begin tick(); lat++; end
      read_req = 1'b1;
      tick(); read_req = 1'b0; lat++;
      while (wr_done_cnt == 0 && lat < 200) begin tick(); lat++; end
      chk("sim_wr_latency", 64'(lat), 64'd33);
      repeat (5) tick();
      chk("sim_wr_beats", 64'(wr_beats), 64'd32);
      chk("sim_wr_data_addr", 64'(wr_bad), 64'd0);
      chk("sim_rd_reqs", 64'(rd_reqs), 64'd0);
      chk("sim_rd_done", 64'(rd_done_cnt), 64'd0);
      chk_line("sim_payload_kept", read_payload, exp_rd);

      // 6: reset in the middle of a read, then a clean read of line 5
      clear_counts(); rd_base = 32'h200; read_id = 19'h00045; read_req = 1'b1;
      tick(); read_req = 1'b0; lat = 1;
      while (rd_reqs < 10 && lat < 200) begin tick(); lat++; end
      chk("abort_reached_beat10", 64'(rd_reqs), 64'd10);
      rst = 1'b0;
      tick();
      rst = 1'b1; rsp_q.delete();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rdreq", 64'(mem_rd_req), 64'd0);
      chk("abort_addr", 64'(mem_addr), 64'd0);
      chk_line("abort_payload", read_payload, '0);
      repeat (5) tick();
      chk("abort_no_done", 64'(rd_done_cnt), 64'd0);
      clear_counts(); rd_base = 32'h500; read_id = 19'h000A0; read_req = 1'b1;
      tick(); read_req = 1'b0; lat = 1;
      while (rd_done_cnt == 0 && lat < 200) begin tick(); lat++; end
      chk("rerd_latency", 64'(lat), 64'd34);
      chk_line("rerd_payload", read_payload, exp_rd);
      repeat (3) tick();
      chk("rerd_req_count", 64'(rd_reqs), 64'd32);
      chk("rerd_addr_seq", 64'(rd_bad), 64'd0);
      chk("rerd_addr_hold", 64'(mem_addr), 64'h5F8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
